rsa_modexp_ctrl: RTL

//  Sequencer computing C = M^E mod N by right-to-left square-and-multiply over one shared rsa_core_mod reduction core.

---
 rtl/rsa_modexp_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer driving one shared modular reduction core.
// Optional RSA_MODEXP_OPCNT_EN adds exp_ops, a saturating count of core operations issued.
module rsa_modexp_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    exp_clk,
  input  logic                    exp_rst,
  input  logic                    exp_start,
  input  logic [DATA_WIDTH-1:0]   exp_m,
  input  logic [DATA_WIDTH-1:0]   exp_e,
  input  logic [DATA_WIDTH-1:0]   exp_n,
  output logic                    exp_busy,
  output logic                    exp_done,
  output logic                    exp_err,
  output logic [DATA_WIDTH-1:0]   exp_c,
  output logic                    mod_start,
  output logic [2*DATA_WIDTH-1:0] mod_a,
  output logic [DATA_WIDTH-1:0]   mod_b,
  input  logic                    mod_done,
  input  logic                    mod_err,
  input  logic [DATA_WIDTH-1:0]   mod_c
`ifdef RSA_MODEXP_OPCNT_EN
  ,
  output logic [7:0]              exp_ops
`endif
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    OP_ONE,
    OP_RED,
    OP_MUL,
    OP_SQR
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  logic [W-1:0]   m_q;
  logic [W-1:0]   n_q;
  logic [W-1:0]   r_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   e_q;
  logic [W-1:0]   res_q;
  logic [2*W-1:0] mod_a_q;
  logic [W-1:0]   exp_c_q;
  logic           exp_err_q;
  logic           exp_done_q;

  logic [2*W-1:0] operand;
  logic [W-1:0]   e_cur;
  logic           is_one;
  logic           go_mul;
  logic           go_done;

  // Zero-extend both factors so the product keeps all 2W bits.
  always_comb begin
    operand = '0;
    unique case (op_q)
      OP_ONE: operand = {{(2*W-1){1'b0}}, 1'b1};
      OP_RED: operand = {{W{1'b0}}, m_q};
      OP_MUL: operand = {{W{1'b0}}, r_q} * {{W{1'b0}}, b_q};
      OP_SQR: operand = {{W{1'b0}}, b_q} * {{W{1'b0}}, b_q};
      default: operand = '0;
    endcase
  end

  // A square consumes one exponent bit before the next multiply test.
  always_comb begin
    e_cur   = (op_q == OP_SQR) ? (e_q >> 1) : e_q;
    is_one  = (op_q == OP_ONE);
    go_mul  = !is_one && (op_q != OP_MUL) && e_cur[0];
    go_done = !is_one && !go_mul && (e_cur[W-1:1] == '0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (exp_start) begin
          state_d = S_DRAIN;
          op_d    = OP_ONE;
        end
      end
      S_DRAIN: begin
        if (!mod_done) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mod_done) state_d = mod_err ? S_ERROR : S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_DRAIN;
        unique case (1'b1)
          is_one:  op_d = OP_RED;
          go_mul:  op_d = OP_MUL;
          go_done: state_d = S_DONE;
          default: op_d = OP_SQR;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge exp_clk) begin
    if (exp_rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ONE;
      m_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      b_q        <= '0;
      e_q        <= '0;
      res_q      <= '0;
      mod_a_q    <= '0;
      exp_c_q    <= '0;
      exp_err_q  <= 1'b0;
      exp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      exp_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (exp_start) begin
            m_q       <= exp_m;
            n_q       <= exp_n;
            e_q       <= exp_e;
            exp_err_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!mod_done) mod_a_q <= operand;
        end
        S_WAIT: begin
          if (mod_done && !mod_err) res_q <= mod_c;
        end
        S_UPDATE: begin
          e_q <= e_cur;
          unique case (op_q)
            OP_ONE, OP_MUL: r_q <= res_q;
            OP_RED, OP_SQR: b_q <= res_q;
            default: r_q <= r_q;
          endcase
        end
        S_DONE: begin
          exp_c_q    <= r_q;
          exp_err_q  <= 1'b0;
          exp_done_q <= 1'b1;
        end
        S_ERROR: begin
          exp_c_q    <= '1;
          exp_err_q  <= 1'b1;
          exp_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RSA_MODEXP_OPCNT_EN
  logic [7:0] ops_q;

  always_ff @(posedge exp_clk) begin
    if (exp_rst) begin
      ops_q <= '0;
    end else if (state_q == S_IDLE && exp_start) begin
      ops_q <= '0;
    end else if (state_q == S_ISSUE && ops_q != 8'hFF) begin
      ops_q <= ops_q + 8'd1;
    end
  end

  assign exp_ops = ops_q;
`endif

  assign exp_busy  = (state_q != S_IDLE);
  assign exp_done  = exp_done_q;
  assign exp_err   = exp_err_q;
  assign exp_c     = exp_c_q;
  assign mod_start = (state_q == S_ISSUE);
  assign mod_a     = mod_a_q;
  assign mod_b     = n_q;

endmodule
